matmul_scheduler: RTL and testbench

MATMUL_SCHEDULER -- requirements
Module: matmul_scheduler

---
 rtl/matmul_scheduler_pkg.sv | 29 ++
 rtl/sched_counter.sv | 29 ++
 rtl/matmul_scheduler.sv | 162 ++++++++++++++++
 tb/tb_matmul_scheduler.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/matmul_scheduler_pkg.sv
// Shared definitions for the matmul scheduler: state encoding, array size
// and the length of the skewed operand feed.
package matmul_scheduler_pkg;

  // Array dimension for the default 64-bit row of 16-bit elements.
  localparam int MAX_DIM = 64 / 16;

  // Feed index width; covers the longest feed (4 + 2*4 - 2 = 10 steps).
  localparam int FEED_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FEED,
    ST_DRAIN,
    ST_WRITE,
    ST_DONE
  } state_t;

  // Number of feed steps: K + 2*dim - 2, where K = dim_k + 1.
  // The skew adds dim-1 steps on entry and dim-1 on exit.
  function automatic logic [FEED_W-1:0] feed_len(input logic [1:0] dim_k,
                                                 input int max_dim = MAX_DIM);
    int len;
    len = int'(dim_k) + 1 + 2 * max_dim - 2;
    return FEED_W'(len);
  endfunction

endpackage

// File: rtl/sched_counter.sv
// Up-counter with synchronous load, enable and terminal flag. It stops at
// the limit instead of wrapping.
module sched_counter #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         reset_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  input  logic [W-1:0] limit_i,
  output logic [W-1:0] count_o,
  output logic         tc_o
);

  // Count register: load wins over enable, and counting stops at the limit.
  always_ff @(posedge clk_i or posedge reset_ni) begin
    if (reset_ni) begin
      count_o <= '0;
    end else if (load_i) begin
      count_o <= load_val_i;
    end else if (en_i && !tc_o) begin
      count_o <= count_o + 1'b1;
    end
  end

  assign tc_o = (count_o == limit_i);

endmodule

// File: rtl/matmul_scheduler.sv
// Sequencer for a systolic matrix multiply: operand row load, skewed feed,
// drain, scratchpad write-back and completion pulse. Every output is a
// register loaded from the next-state decode.
//
// Control handshake: start_i is a request that is accepted only when the
// block is idle (busy_o low); a start seen while busy is refused with a
// one-cycle err_o. hold_i is a stall: while high in LOAD or FEED nothing
// advances and the row/feed strobes are low for that cycle.
module matmul_scheduler
  import matmul_scheduler_pkg::*;
#(
  parameter  int data_width = 16,
  parameter  int bus_width  = 64,
  localparam int max_dim    = bus_width / data_width,
  localparam int row_w      = $clog2(max_dim)
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             start_i,
  input  logic             mode_i,
  input  logic [1:0]       dim_n_i,
  input  logic [1:0]       dim_k_i,
  input  logic [1:0]       dim_m_i,
  input  logic [1:0]       write_target_i,
  input  logic             hold_i,
  output logic             rf_rd_en_o,
  output logic [row_w-1:0] rf_rd_row_o,
  output logic             sa_clear_o,
  output logic             sa_preload_o,
  output logic             feed_valid_o,
  output logic [3:0]       feed_idx_o,
  output logic             sp_we_o,
  output logic [1:0]       sp_target_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  state_t              state_q, state_d;
  logic [1:0]          dim_k_q;
  logic                row_tc, feed_tc;
  logic [FEED_W-1:0]   feed_lim;
  logic                start_ok, row_en, feed_en, feed_clr;
  logic                rd_en_d, clear_d, preload_d, feed_valid_d;
  logic                we_d, done_d, err_d;

  // N and M only shape the operand rows upstream; the sequence length
  // depends on K alone.
  logic unused_dims;
  assign unused_dims = ^{dim_n_i, dim_m_i};

  assign feed_lim = feed_len(dim_k_q, max_dim) - 1'b1;
  assign start_ok = (state_q == ST_IDLE) && start_i;
  assign row_en   = (state_q == ST_LOAD) && !hold_i;
  assign feed_en  = (state_q == ST_FEED) && !hold_i;
  assign feed_clr = start_ok || (feed_en && feed_tc);

  sched_counter #(.W(row_w)) u_row_cnt (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .load_i     (start_ok),
    .load_val_i ('0),
    .en_i       (row_en),
    .limit_i    (row_w'(max_dim - 1)),
    .count_o    (rf_rd_row_o),
    .tc_o       (row_tc)
  );

  sched_counter #(.W(FEED_W)) u_feed_cnt (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .load_i     (feed_clr),
    .load_val_i ('0),
    .en_i       (feed_en),
    .limit_i    (feed_lim),
    .count_o    (feed_idx_o),
    .tc_o       (feed_tc)
  );

  // Next-state and next-output decode; outputs describe the coming cycle.
  always_comb begin
    state_d      = state_q;
    rd_en_d      = 1'b0;
    clear_d      = 1'b0;
    preload_d    = 1'b0;
    feed_valid_d = 1'b0;
    we_d         = 1'b0;
    done_d       = 1'b0;
    err_d        = start_i && (state_q != ST_IDLE);
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d   = ST_LOAD;
          rd_en_d   = 1'b1;
          clear_d   = !mode_i;
          preload_d = mode_i;
        end
      end
      ST_LOAD: begin
        if (!hold_i) begin
          if (row_tc) begin
            state_d      = ST_FEED;
            feed_valid_d = 1'b1;
          end else begin
            rd_en_d = 1'b1;
          end
        end
      end
      ST_FEED: begin
        if (!hold_i) begin
          if (feed_tc) begin
            state_d = ST_DRAIN;
          end else begin
            feed_valid_d = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        state_d = ST_WRITE;
        we_d    = 1'b1;
      end
      ST_WRITE: begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State, operand latches and registered outputs.
  always_ff @(posedge clk_i or posedge reset_ni) begin
    if (reset_ni) begin
      state_q      <= ST_IDLE;
      dim_k_q      <= '0;
      sp_target_o  <= '0;
      rf_rd_en_o   <= 1'b0;
      sa_clear_o   <= 1'b0;
      sa_preload_o <= 1'b0;
      feed_valid_o <= 1'b0;
      sp_we_o      <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      state_q      <= state_d;
      if (start_ok) begin
        dim_k_q     <= dim_k_i;
        sp_target_o <= write_target_i;
      end
      rf_rd_en_o   <= rd_en_d;
      sa_clear_o   <= clear_d;
      sa_preload_o <= preload_d;
      feed_valid_o <= feed_valid_d;
      sp_we_o      <= we_d;
      busy_o       <= (state_d != ST_IDLE);
      done_o       <= done_d;
      err_o        <= err_d;
    end
  end

endmodule

// File: tb/tb_matmul_scheduler.sv
// Directed bench for matmul_scheduler. Cycle numbering: the start request is
// sampled at edge 0 and cycle n is the period that follows.
module tb_matmul_scheduler;

  logic       clk_i          = 1'b0;
  logic       reset_ni       = 1'b0;
  logic       start_i        = 1'b0;
  logic       mode_i         = 1'b0;
  logic [1:0] dim_n_i        = 2'd0;
  logic [1:0] dim_k_i        = 2'd0;
  logic [1:0] dim_m_i        = 2'd0;
  logic [1:0] write_target_i = 2'd0;
  logic       hold_i         = 1'b0;

  logic       rf_rd_en_o;
  logic [1:0] rf_rd_row_o;
  logic       sa_clear_o;
  logic       sa_preload_o;
  logic       feed_valid_o;
  logic [3:0] feed_idx_o;
  logic       sp_we_o;
  logic [1:0] sp_target_o;
  logic       busy_o;
  logic       done_o;
  logic       err_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Clock and reset
  always #5 clk_i = ~clk_i;

  matmul_scheduler #(.data_width(16), .bus_width(64)) dut (
    .clk_i          (clk_i),
    .reset_ni       (reset_ni),
    .start_i        (start_i),
    .mode_i         (mode_i),
    .dim_n_i        (dim_n_i),
    .dim_k_i        (dim_k_i),
    .dim_m_i        (dim_m_i),
    .write_target_i (write_target_i),
    .hold_i         (hold_i),
    .rf_rd_en_o     (rf_rd_en_o),
    .rf_rd_row_o    (rf_rd_row_o),
    .sa_clear_o     (sa_clear_o),
    .sa_preload_o   (sa_preload_o),
    .feed_valid_o   (feed_valid_o),
    .feed_idx_o     (feed_idx_o),
    .sp_we_o        (sp_we_o),
    .sp_target_o    (sp_target_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .err_o          (err_o)
  );

  task automatic chk(input string tag, input int cyc, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_en"},    -1, rf_rd_en_o,   0);
    chk({tag, "_row"},      -1, rf_rd_row_o,  0);
    chk({tag, "_clear"},    -1, sa_clear_o,   0);
    chk({tag, "_preload"},  -1, sa_preload_o, 0);
    chk({tag, "_fvalid"},   -1, feed_valid_o, 0);
    chk({tag, "_fidx"},     -1, feed_idx_o,   0);
    chk({tag, "_we"},       -1, sp_we_o,      0);
    chk({tag, "_target"},   -1, sp_target_o,  0);
    chk({tag, "_busy"},     -1, busy_o,       0);
    chk({tag, "_done"},     -1, done_o,       0);
    chk({tag, "_err"},      -1, err_o,        0);
  endtask

  // Driver: present a start with operands, let edge 0 sample it, then
  // scramble the operand inputs to prove they were latched.
  task automatic launch(input logic [1:0] k, input logic mode,
                        input logic [1:0] tgt, input logic hold_too);
    start_i        = 1'b1;
    dim_k_i        = k;
    mode_i         = mode;
    write_target_i = tgt;
    hold_i         = hold_too;
    dim_n_i        = 2'($urandom_range(0, 3));
    dim_m_i        = 2'($urandom_range(0, 3));
    tick();
    start_i        = 1'b0;
    hold_i         = 1'b0;
    dim_k_i        = 2'($urandom_range(0, 3));
    mode_i         = 1'($urandom_range(0, 1));
    write_target_i = 2'($urandom_range(0, 3));
  endtask

  // Walk cycles 1..done_at+1 checking every output against the expected
  // schedule: LOAD 1-4, FEED 5..feed_last, write at done_at-1, done at
  // done_at. hold_i is driven in cycles hold_lo..hold_hi (stalls show one
  // cycle later); a stray start is driven in cycle err_cyc.
  task automatic timeline(input logic mode, input logic [1:0] tgt,
                          input int feed_last, input int done_at,
                          input int hold_lo, input int hold_hi,
                          input int err_cyc);
    for (int c = 1; c <= done_at + 1; c++) begin
      int   held_before;
      logic held_now;
      logic in_feed;
      hold_i  = (c >= hold_lo) && (c <= hold_hi);
      start_i = (c == err_cyc);
      held_now = (c >= hold_lo + 1) && (c <= hold_hi + 1);
      held_before = 0;
      for (int h = hold_lo + 1; h <= hold_hi + 1; h++) begin
        if (h <= c) held_before++;
      end
      in_feed = (c >= 5) && (c <= feed_last);
      chk("rd_en", c, rf_rd_en_o, (c <= 4));
      if (c <= 4) chk("row", c, rf_rd_row_o, c - 1);
      chk("fvalid",  c, feed_valid_o, in_feed && !held_now);
      chk("fidx",    c, feed_idx_o, in_feed ? (c - 5 - held_before) : 0);
      chk("clear",   c, sa_clear_o,   (c == 1) && !mode);
      chk("preload", c, sa_preload_o, (c == 1) && mode);
      chk("we",      c, sp_we_o,  (c == done_at - 1));
      chk("done",    c, done_o,   (c == done_at));
      chk("busy",    c, busy_o,   (c <= done_at));
      chk("err",     c, err_o,    (c == err_cyc + 1));
      chk("target",  c, sp_target_o, tgt);
      if (c <= done_at) tick();
    end
    start_i = 1'b0;
    hold_i  = 1'b0;
  endtask

  initial begin
    // Power-on reset, checked before any clock edge.
    #1 reset_ni = 1'b1;
    #1;
    chk_all_zero("por");
    tick();
    tick();
    reset_ni = 1'b0;
    tick();
    chk_all_zero("idle");

    // K=4, fresh product: FEED 5-14, write 16, done 17.
    launch(2'd3, 1'b0, 2'd1, 1'b0);
    timeline(1'b0, 2'd1, 14, 17, 0, -1, -10);

    // K=1: FEED 5-11 with feed_idx_o reaching 6, done 14.
    launch(2'd0, 1'b0, 2'd3, 1'b0);
    timeline(1'b0, 2'd3, 11, 14, 0, -1, -10);

    // Hold in cycles 7-9: feed index parks at 2, done slips to 20.
    launch(2'd3, 1'b0, 2'd0, 1'b0);
    timeline(1'b0, 2'd0, 17, 20, 7, 9, -10);

    // Start while busy (cycle 6): err at 7, schedule unchanged.
    launch(2'd3, 1'b0, 2'd1, 1'b0);
    timeline(1'b0, 2'd1, 14, 17, 0, -1, 6);

    // Start while in DONE (cycle 17): refused, block stays idle.
    launch(2'd3, 1'b0, 2'd2, 1'b0);
    timeline(1'b0, 2'd2, 14, 17, 0, -1, 17);
    tick();
    chk("post_reject_busy", 19, busy_o, 0);
    chk("post_reject_err",  19, err_o,  0);

    // Accumulate mode, target 2, hold high alongside start in IDLE.
    launch(2'd3, 1'b1, 2'd2, 1'b1);
    timeline(1'b1, 2'd2, 14, 17, 0, -1, -10);

    // Reset in the middle of FEED (cycle 10) aborts without done.
    launch(2'd3, 1'b0, 2'd1, 1'b0);
    repeat (9) tick();
    chk("pre_reset_fvalid", 10, feed_valid_o, 1);
    chk("pre_reset_fidx",   10, feed_idx_o,   5);
    #2 reset_ni = 1'b1;
    #1;
    chk_all_zero("mid_reset");
    tick();
    reset_ni = 1'b0;
    for (int c = 0; c < 20; c++) begin
      chk("abort_done", c, done_o, 0);
      chk("abort_busy", c, busy_o, 0);
      tick();
    end

    // A fresh start after the abort completes normally.
    launch(2'd3, 1'b0, 2'd3, 1'b0);
    timeline(1'b0, 2'd3, 14, 17, 0, -1, -10);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
